// File: rtl/rom_load_sequencer.sv
// Steers the HPS ioctl ROM download into three on-chip ROM regions and keeps the
// Battlezone core in reset until a complete, in-range image has loaded and settled.
module rom_load_sequencer #(
    parameter int R0_SIZE = 12288,
    parameter int R1_SIZE = 4096,
    parameter int R2_SIZE = 1024,
    parameter int AW      = 14,
    parameter int SETTLE  = 255
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ioctl_download,
    input  logic          ioctl_wr,
    input  logic [24:0]   ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    output logic [2:0]    rom_we,
    output logic [AW-1:0] rom_waddr,
    output logic [7:0]    rom_wdata,
    output logic          cpu_hold,
    output logic          load_ok,
    output logic          load_err
);

    localparam int TOTAL = R0_SIZE + R1_SIZE + R2_SIZE;
    localparam int CW    = $clog2(TOTAL + 1);

    localparam logic [24:0]   R1_BASE     = 25'(R0_SIZE);
    localparam logic [24:0]   R2_BASE     = 25'(R0_SIZE + R1_SIZE);
    localparam logic [24:0]   IMAGE_END   = 25'(TOTAL);
    localparam logic [CW-1:0] TOTAL_CNT   = CW'(TOTAL);
    localparam logic [15:0]   SETTLE_LAST = 16'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_BOOT,
        S_LOAD,
        S_CHECK,
        S_SETTLE,
        S_RUN
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] byte_cnt;
    logic          overflow;
    logic [15:0]   settle_cnt;

    logic          image_ok;
    logic          load_wr;
    logic [2:0]    we_dec;
    logic [24:0]   offset;

    assign image_ok = (byte_cnt == TOTAL_CNT) && !overflow;
    assign load_wr  = (state == S_LOAD) && ioctl_wr;
    assign cpu_hold = (state != S_RUN);

    // Region decode on the full 25-bit address, so high bits never alias into range.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        we_dec = 3'b000;
        offset = '0;
        if (ioctl_addr < R1_BASE) begin
            we_dec = 3'b001;
            offset = ioctl_addr;
        end else if (ioctl_addr < R2_BASE) begin
            we_dec = 3'b010;
            offset = ioctl_addr - R1_BASE;
        end else if (ioctl_addr < IMAGE_END) begin
            we_dec = 3'b100;
            offset = ioctl_addr - R2_BASE;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_BOOT:   if (ioctl_download) state_next = S_LOAD;
            S_LOAD:   if (!ioctl_download) state_next = S_CHECK;
            S_CHECK:  state_next = image_ok ? S_SETTLE : S_BOOT;
            S_SETTLE: begin
                if (ioctl_download)                 state_next = S_LOAD;
                else if (settle_cnt == SETTLE_LAST) state_next = S_RUN;
            end
            S_RUN:    if (ioctl_download) state_next = S_LOAD;
            default:  state_next = S_BOOT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is sampled on the clock edge.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= S_BOOT;
            rom_we     <= 3'b000;
            rom_waddr  <= '0;
            rom_wdata  <= '0;
            load_ok    <= 1'b0;
            load_err   <= 1'b0;
            byte_cnt   <= '0;
            overflow   <= 1'b0;
            settle_cnt <= '0;
        end else begin
            state  <= state_next;
            rom_we <= 3'b000;

            if (state != S_LOAD && state_next == S_LOAD) begin
                byte_cnt <= '0;
                overflow <= 1'b0;
                load_ok  <= 1'b0;
                load_err <= 1'b0;
            end

            // A strobe in the cycle download falls still lands before CHECK looks at the count.
            if (load_wr) begin
                if (we_dec != 3'b000) begin
                    rom_we    <= we_dec;
                    rom_waddr <= offset[AW-1:0];
                    rom_wdata <= ioctl_dout;
                    if (byte_cnt != TOTAL_CNT) byte_cnt <= byte_cnt + CW'(1);
                end else begin
                    overflow <= 1'b1;
                end
            end

            if (state == S_CHECK) begin
                load_ok  <= image_ok;
                load_err <= !image_ok;
            end

            if (state == S_CHECK)       settle_cnt <= '0;
            else if (state == S_SETTLE) settle_cnt <= settle_cnt + 16'd1;
        end
    end

endmodule
